complex_mult: RTL and testbench



---
 rtl/complex_pkg.sv | 22 ++
 rtl/complex_mult_if.sv | 25 ++
 rtl/smul8.sv | 26 ++
 rtl/complex_mult.sv | 61 ++++++
 tb/tb_complex_mult.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/complex_pkg.sv
// Shared widths, operand struct and wrap helpers for the complex multiplier datapath.
// Pure definitions: no latency, no backpressure.
package complex_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef struct packed {
    logic signed [OP_W-1:0] re;
    logic signed [OP_W-1:0] im;
  } cplx_in_t;

  function automatic logic signed [RES_W:0] ext_res(input logic signed [RES_W-1:0] p);
    return {p[RES_W-1], p};
  endfunction

  // Two's-complement wrap back to result width; the only case that wraps is all operands = -128.
  function automatic logic signed [RES_W-1:0] wrap_res(input logic signed [RES_W:0] v);
    return RES_W'(v);
  endfunction

endpackage

// File: rtl/complex_mult_if.sv
// Operand/result bundle for complex_mult; master drives operands, slave returns the product.
// No backpressure: data_valid[0] is a strobe, z_valid a one-cycle pulse.
interface complex_mult_if;
  import complex_pkg::*;

  logic signed [OP_W-1:0]  a_real;
  logic signed [OP_W-1:0]  a_imag;
  logic signed [OP_W-1:0]  b_real;
  logic signed [OP_W-1:0]  b_imag;
  logic [1:0]              data_valid;
  logic signed [RES_W-1:0] z_real;
  logic signed [RES_W-1:0] z_imag;
  logic                    z_valid;

  modport master (
    output a_real, a_imag, b_real, b_imag, data_valid,
    input  z_real, z_imag, z_valid
  );

  modport slave (
    input  a_real, a_imag, b_real, b_imag, data_valid,
    output z_real, z_imag, z_valid
  );

endinterface

// File: rtl/smul8.sv
// Registered 8x8 signed multiplier, 1-cycle latency; product holds while i_en is low.
// No backpressure.
module smul8
  import complex_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [OP_W-1:0]  i_a,
  input  logic signed [OP_W-1:0]  i_b,
  output logic signed [RES_W-1:0] o_p
);

  logic signed [RES_W-1:0] r_p;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= RES_W'(i_a) * RES_W'(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/complex_mult.sv
// Pipelined signed complex multiply z = a*b: partial products in stage 1, add/sub in stage 2, latency 2.
// No backpressure: one result per strobe, outputs hold between results.
module complex_mult
  import complex_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  complex_mult_if.slave  bus
);

  cplx_in_t w_a;
  cplx_in_t w_b;
  logic     w_vld;

  assign w_a   = {bus.a_real, bus.a_imag};
  assign w_b   = {bus.b_real, bus.b_imag};
  // Bit 1 of the strobe is reserved; only bit 0 qualifies a sample.
  assign w_vld = (bus.data_valid & 2'b01) != 2'b00;

  logic signed [RES_W-1:0] w_pp_rr;
  logic signed [RES_W-1:0] w_pp_ii;
  logic signed [RES_W-1:0] w_pp_ri;
  logic signed [RES_W-1:0] w_pp_ir;

  smul8 u_mul_rr (.i_clk(clk), .i_rst(rst), .i_en(w_vld), .i_a(w_a.re), .i_b(w_b.re), .o_p(w_pp_rr));
  smul8 u_mul_ii (.i_clk(clk), .i_rst(rst), .i_en(w_vld), .i_a(w_a.im), .i_b(w_b.im), .o_p(w_pp_ii));
  smul8 u_mul_ri (.i_clk(clk), .i_rst(rst), .i_en(w_vld), .i_a(w_a.re), .i_b(w_b.im), .o_p(w_pp_ri));
  smul8 u_mul_ir (.i_clk(clk), .i_rst(rst), .i_en(w_vld), .i_a(w_a.im), .i_b(w_b.re), .o_p(w_pp_ir));

  logic signed [RES_W:0] w_re_full;
  logic signed [RES_W:0] w_im_full;

  assign w_re_full = ext_res(w_pp_rr) - ext_res(w_pp_ii);
  assign w_im_full = ext_res(w_pp_ri) + ext_res(w_pp_ir);

  logic                    r_s1_vld;
  logic signed [RES_W-1:0] r_z_real;
  logic signed [RES_W-1:0] r_z_imag;
  logic                    r_z_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_z_real  <= '0;
      r_z_imag  <= '0;
      r_z_valid <= 1'b0;
    end else begin
      r_s1_vld  <= w_vld;
      r_z_valid <= r_s1_vld;
      if (r_s1_vld) begin
        r_z_real <= wrap_res(w_re_full);
        r_z_imag <= wrap_res(w_im_full);
      end
    end
  end

  assign bus.z_real  = r_z_real;
  assign bus.z_imag  = r_z_imag;
  assign bus.z_valid = r_z_valid;

endmodule

// File: tb/tb_complex_mult.sv
// Directed plus random stimulus for complex_mult, checked against a queue-based arithmetic model.
module tb_complex_mult;
  import complex_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  complex_mult_if bus();

  complex_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int due;
    int re;
    int im;
  } exp_t;

  exp_t q[$];
  int   m_re  = 0;
  int   m_im  = 0;
  bit   m_vld = 1'b0;

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".z_valid"}, {31'd0, bus.z_valid}, m_vld ? 1 : 0);
    chk({tag, ".z_real"},  32'(bus.z_real), m_re);
    chk({tag, ".z_imag"},  32'(bus.z_imag), m_im);
  endtask

  // Drive one cycle of inputs, advance one edge, update the model and compare.
  task automatic step(input string tag, input bit r, input logic [1:0] dv,
                      input int ar, input int ai, input int br, input int bi);
    rst            = r;
    bus.data_valid = dv;
    bus.a_real     = 8'(ar);
    bus.a_imag     = 8'(ai);
    bus.b_real     = 8'(br);
    bus.b_imag     = 8'(bi);
    @(posedge clk);
    #1;
    edge_n++;
    if (r) begin
      q.delete();
      m_re  = 0;
      m_im  = 0;
      m_vld = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        m_vld = 1'b1;
        m_re  = q[0].re;
        m_im  = q[0].im;
        void'(q.pop_front());
      end
      if (dv[0]) begin
        q.push_back('{edge_n + 1, wrap16(ar * br - ai * bi), wrap16(ar * bi + ai * br)});
      end
    end
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 2'b00, 0, 0, 0, 0);
  endtask

  // Strobe once, then one idle edge; the result is visible after that second edge.
  task automatic single(input string tag, input int ar, input int ai, input int br, input int bi,
                        input int er, input int ei);
    step(tag, 1'b0, 2'b01, ar, ai, br, bi);
    idle(tag);
    chk({tag, ".const_valid"}, {31'd0, bus.z_valid}, 1);
    chk({tag, ".const_re"}, 32'(bus.z_real), er);
    chk({tag, ".const_im"}, 32'(bus.z_imag), ei);
    idle(tag);
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_valid = 2'b00;
    bus.a_real     = '0;
    bus.a_imag     = '0;
    bus.b_real     = '0;
    bus.b_imag     = '0;

    step("reset", 1'b1, 2'b00, 0, 0, 0, 0);
    step("reset", 1'b1, 2'b00, 0, 0, 0, 0);
    chk("reset.const_re", 32'(bus.z_real), 0);
    chk("reset.const_valid", {31'd0, bus.z_valid}, 0);

    single("v1", 1, 2, 3, 4, -5, 10);
    single("v2", 2, 4, 6, 8, -20, 40);
    single("v3", 1, 3, 5, 7, -16, 22);
    single("v4", 1, 2, 1, 2, -3, 4);
    single("v5", 3, 4, 5, 6, -9, 38);

    for (int i = 0; i < 4; i++) begin
      step("hold", 1'b0, 2'b00, int'($urandom_range(255)), int'($urandom_range(255)),
           int'($urandom_range(255)), int'($urandom_range(255)));
    end
    chk("hold.const_re", 32'(bus.z_real), -9);

    step("b2b", 1'b0, 2'b01, 1, 2, 3, 4);
    step("b2b", 1'b0, 2'b01, 2, 4, 6, 8);
    chk("b2b.first_re", 32'(bus.z_real), -5);
    step("b2b", 1'b0, 2'b01, 1, 3, 5, 7);
    chk("b2b.second_re", 32'(bus.z_real), -20);
    idle("b2b");
    chk("b2b.third_im", 32'(bus.z_imag), 22);
    chk("b2b.third_valid", {31'd0, bus.z_valid}, 1);
    idle("b2b");

    single("ext_neg", -128, -128, -128, -128, 0, -32768);
    single("ext_mix", 127, 127, -128, 0, -16256, -16256);

    step("rst_mid", 1'b0, 2'b01, 3, 4, 5, 6);
    step("rst_mid", 1'b1, 2'b00, 0, 0, 0, 0);
    idle("rst_mid");
    chk("rst_mid.const_re", 32'(bus.z_real), 0);
    chk("rst_mid.const_valid", {31'd0, bus.z_valid}, 0);
    idle("rst_mid");

    step("rst_dv", 1'b1, 2'b01, 5, 6, 7, 8);
    idle("rst_dv");
    chk("rst_dv.const_valid", {31'd0, bus.z_valid}, 0);
    single("after_rst", 1, 2, 1, 2, -3, 4);

    step("dv10", 1'b0, 2'b10, 9, 9, 9, 9);
    idle("dv10");
    chk("dv10.const_valid", {31'd0, bus.z_valid}, 0);
    chk("dv10.const_re", 32'(bus.z_real), -3);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(39) == 0), 2'($urandom_range(3)),
           int'($signed(8'($urandom))), int'($signed(8'($urandom))),
           int'($signed(8'($urandom))), int'($signed(8'($urandom))));
    end
    idle("drain");
    idle("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
